// File: rtl/spi_responder_pkg.sv
// Shared SPI definitions used by the responder and by the existing
// sender/receiver: FSM state encoding and the default frame/synchroniser sizes.
package spi_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_responder_if.sv
// Bus bundle for the SPI responder: the incoming SPI pins (SCLK, SS_N, MOSI)
// and the parallel host side (TX buffer write, RX holding register read, flags).
// MISO is tri-stated and therefore kept as a plain port on the responder.
//   slave  : the responder's view (pins and host strobes in, status out)
//   master : the initiator/host view (the opposite directions)
interface spi_responder_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) ();

    logic                  SCLK;
    logic                  SS_N;
    logic                  MOSI;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  WRITE;
    logic                  TX_EMPTY;
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  RX_VALID;
    logic                  READ;
    logic                  OVERRUN;
    logic                  ABORT;
    logic                  BUSY;

    modport slave (
        input  SCLK, SS_N, MOSI, TX_DATA, WRITE, READ,
        output TX_EMPTY, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY
    );

    modport master (
        output SCLK, SS_N, MOSI, TX_DATA, WRITE, READ,
        input  TX_EMPTY, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY
    );

endinterface

// File: rtl/spi_responder_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rise/fall
// detector. The edge pulses are combinational from the last synchroniser flop
// and the history flop, so the consumer acts on them one cycle after the
// synchronised level appears.
//   clk, rst : local clock, asynchronous active-high reset
//   pin      : asynchronous input
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
// Every flop resets to 0. For SS_N this means a select already held low when
// reset is released produces no fall until the pin has gone high first.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   level_s;

    assign level_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain and edge-detect history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
            prev_r <= level_s;
        end
    end

    assign rise = level_s & ~prev_r;
    assign fall = ~level_s & prev_r;

endmodule

// File: rtl/spi_responder.sv
// SPI responder (mode 0, LSB first), fully in the local CLK domain.
// SCLK and SS_N are synchronised with edge detection; MOSI is synchronised only
// and sampled on the synchronised SCLK rise.
//   CLK, CLR : local clock, asynchronous active-high reset
//   bus      : SPI pins in, TX buffer write, RX holding register and flags
//   MISO     : serial data out, high-Z whenever the block is not busy
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic           CLK,
    input  logic           CLR,
    spi_responder_if.slave bus,
    output wire            MISO
);

    localparam int                   CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

    spi_state_e             state_r;
    spi_state_e             state_next_s;
    logic                   busy_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   mosi_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   ss_rise_s;
    logic                   ss_fall_s;
    logic [DATA_WIDTH-1:0]  tx_buf_r;
    logic                   tx_empty_r;
    logic [DATA_WIDTH-1:0]  tx_shreg_r;
    logic [DATA_WIDTH-1:0]  tx_word_s;
    logic                   miso_r;
    logic                   hold_r;
    logic [DATA_WIDTH-1:0]  rx_shreg_r;
    logic [DATA_WIDTH-1:0]  rx_data_r;
    logic                   rx_valid_r;
    logic                   overrun_r;
    logic                   abort_r;
    logic                   load_s;
    logic                   complete_s;
    logic                   rx_shift_s;
    logic                   tx_fall_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (CLK),
        .rst  (CLR),
        .pin  (bus.SCLK),
        .rise (sclk_rise_s),
        .fall (sclk_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (CLK),
        .rst  (CLR),
        .pin  (bus.SS_N),
        .rise (ss_rise_s),
        .fall (ss_fall_s)
    );

    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign load_s     = (state_r == LOAD);
    assign complete_s = (state_r == SHIFT) && (cnt_r == CNT_FULL);
    assign rx_shift_s = (state_r == SHIFT) && sclk_rise_s && (cnt_r != CNT_FULL);
    assign tx_fall_s  = (state_r == SHIFT) && sclk_fall_s;
    // An empty buffer at LOAD time sends all zeros.
    assign tx_word_s  = tx_empty_r ? WORD_ZERO : tx_buf_r;

    // FSM next state; a deselect wins over everything else.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) state_next_s = LOAD;
                else           state_next_s = IDLE;
            end
            LOAD: begin
                if (ss_rise_s) state_next_s = IDLE;
                else           state_next_s = SHIFT;
            end
            SHIFT: begin
                if (ss_rise_s)       state_next_s = IDLE;
                else if (complete_s) state_next_s = LOAD;
                else                 state_next_s = SHIFT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register; BUSY is registered from the next state so it tracks state_r exactly.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Bit counter: counts synchronised SCLK rises within a frame, cleared outside SHIFT.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt_r <= CNT_ZERO;
        end else if (ss_rise_s || complete_s || (state_r != SHIFT)) begin
            cnt_r <= CNT_ZERO;
        end else if (rx_shift_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // MOSI synchroniser and RX shift register (LSB first, so shift in at the MSB).
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            rx_shreg_r  <= WORD_ZERO;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.MOSI};
            if (rx_shift_s) begin
                rx_shreg_r <= {mosi_s, rx_shreg_r[DATA_WIDTH-1:1]};
            end
        end
    end

    // One-entry TX buffer; a LOAD frees the slot in the same cycle, so a coincident WRITE is kept.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tx_buf_r   <= WORD_ZERO;
            tx_empty_r <= 1'b1;
        end else if (bus.WRITE && (tx_empty_r || load_s)) begin
            tx_buf_r   <= bus.TX_DATA;
            tx_empty_r <= 1'b0;
        end else if (load_s) begin
            tx_empty_r <= 1'b1;
        end
    end

    // TX shift register and registered MISO bit. After a completed frame, hold_r
    // keeps the old last bit on MISO and swallows the frame-boundary SCLK fall, so
    // the reloaded word appears only after that fall.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tx_shreg_r <= WORD_ZERO;
            miso_r     <= 1'b0;
            hold_r     <= 1'b0;
        end else if (state_r == IDLE) begin
            hold_r <= 1'b0;
        end else if (load_s) begin
            tx_shreg_r <= tx_word_s;
            if (!hold_r) begin
                miso_r <= tx_word_s[0];
            end
        end else if (complete_s) begin
            hold_r <= 1'b1;
        end else if (tx_fall_s) begin
            if (hold_r) begin
                hold_r <= 1'b0;
            end else begin
                tx_shreg_r <= {1'b0, tx_shreg_r[DATA_WIDTH-1:1]};
            end
        end else if (!hold_r) begin
            miso_r <= tx_shreg_r[0];
        end
    end

    // RX holding register, RX_VALID/OVERRUN bookkeeping and the ABORT pulse.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rx_data_r  <= WORD_ZERO;
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            if (complete_s) begin
                // A coincident READ acknowledges the old word, so the new one is not an overrun.
                rx_data_r  <= rx_shreg_r;
                rx_valid_r <= 1'b1;
                overrun_r  <= bus.READ ? 1'b0 : (overrun_r | rx_valid_r);
            end else if (bus.READ) begin
                rx_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
            end
            abort_r <= ss_rise_s && (cnt_r != CNT_ZERO) && !complete_s;
        end
    end

    assign bus.TX_EMPTY = tx_empty_r;
    assign bus.RX_DATA  = rx_data_r;
    assign bus.RX_VALID = rx_valid_r;
    assign bus.OVERRUN  = overrun_r;
    assign bus.ABORT    = abort_r;
    assign bus.BUSY     = busy_r;
    assign MISO         = busy_r ? miso_r : 1'bz;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder acting as the SPI initiator and the host.
// MISO is pulled up, so a released (high-Z) MISO reads as 1.
module tb_spi_responder;

    localparam int DW    = 8;
    localparam int HALF  = 8;   // SCLK half period in CLK cycles
    localparam int SETUP = 10;  // SS_N fall to first bit, in CLK cycles

    logic       clk;
    logic       rst;
    wire        miso_w;
    int         n_total;
    int         n_pass;
    int         pulses;
    logic [7:0] cap_a;
    logic [7:0] cap_b;

    spi_responder_if #(.DATA_WIDTH(DW)) bus ();
    pullup (miso_w);

    spi_responder #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .CLK  (clk),
        .CLR  (rst),
        .bus  (bus),
        .MISO (miso_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [7:0] w);
        bus.TX_DATA = w;
        bus.WRITE   = 1'b1;
        @(negedge clk);
        bus.WRITE   = 1'b0;
    endtask

    task automatic read_pulse;
        bus.READ = 1'b1;
        @(negedge clk);
        bus.READ = 1'b0;
    endtask

    // Initiator: nbits mode-0 clocks, LSB first; optionally pulses READ in the
    // exact cycle the responder completes the frame (3.5 cycles after the last rise).
    task automatic xfer(input logic [7:0] mosi_byte, input int nbits, input bit read_last,
                        output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = mosi_byte[i];
            cycles(HALF);
            miso_byte[i] = miso_w;
            bus.SCLK = 1'b1;
            if (read_last && (i == nbits - 1)) begin
                cycles(3);
                read_pulse();
                cycles(HALF - 4);
            end else begin
                cycles(HALF);
            end
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic count_abort(input int n);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.ABORT === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cycles(3);
        n_total++; if (bus.TX_EMPTY !== 1'b1) $display("FAIL reset_tx_empty: got %b want 1", bus.TX_EMPTY); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", bus.RX_VALID); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.OVERRUN !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.OVERRUN); else n_pass++;
        n_total++; if (bus.ABORT !== 1'b0) $display("FAIL reset_abort: got %b want 0", bus.ABORT); else n_pass++;
        n_total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.BUSY); else n_pass++;
        n_total++; if (miso_w !== 1'b1) $display("FAIL reset_miso_released: got %b want 1 (pulled)", miso_w); else n_pass++;
        rst = 1'b0;
        count_abort(10);
        n_total++; if (pulses !== 0) $display("FAIL reset_release_abort: got %0d pulses want 0", pulses); else n_pass++;
        n_total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", bus.BUSY); else n_pass++;
    endtask

    task automatic test_basic;
        write_word(8'h3C);
        n_total++; if (bus.TX_EMPTY !== 1'b0) $display("FAIL basic_tx_full: got %b want 0", bus.TX_EMPTY); else n_pass++;
        bus.SS_N = 1'b0;
        cycles(SETUP);
        n_total++; if (bus.BUSY !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.BUSY); else n_pass++;
        n_total++; if (bus.TX_EMPTY !== 1'b1) $display("FAIL basic_tx_empty_after_load: got %b want 1", bus.TX_EMPTY); else n_pass++;
        xfer(8'hA5, 8, 1'b0, cap_a);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (cap_a !== 8'h3C) $display("FAIL basic_miso: got %h want 3c", cap_a); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'hA5) $display("FAIL basic_rx_data: got %h want a5", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b1) $display("FAIL basic_rx_valid: got %b want 1", bus.RX_VALID); else n_pass++;
        n_total++; if (bus.BUSY !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", bus.BUSY); else n_pass++;
        n_total++; if (miso_w !== 1'b1) $display("FAIL basic_miso_released: got %b want 1 (pulled)", miso_w); else n_pass++;
        read_pulse();
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL basic_read_clears: got %b want 0", bus.RX_VALID); else n_pass++;
    endtask

    task automatic test_back_to_back;
        write_word(8'h11);
        bus.SS_N = 1'b0;
        cycles(SETUP);
        write_word(8'h22);
        write_word(8'h99); // buffer full: must be ignored
        xfer(8'h81, 8, 1'b0, cap_a);
        n_total++; if (bus.RX_DATA !== 8'h81) $display("FAIL b2b_rx_first: got %h want 81", bus.RX_DATA); else n_pass++;
        read_pulse();
        xfer(8'h7E, 8, 1'b0, cap_b);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (cap_a !== 8'h11) $display("FAIL b2b_miso_first: got %h want 11", cap_a); else n_pass++;
        n_total++; if (cap_b !== 8'h22) $display("FAIL b2b_miso_second: got %h want 22", cap_b); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'h7E) $display("FAIL b2b_rx_second: got %h want 7e", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.OVERRUN !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", bus.OVERRUN); else n_pass++;
        n_total++; if (bus.TX_EMPTY !== 1'b1) $display("FAIL b2b_tx_empty: got %b want 1", bus.TX_EMPTY); else n_pass++;
        read_pulse();
    endtask

    task automatic test_underrun_overrun;
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'h0F, 8, 1'b0, cap_a);
        xfer(8'hF0, 8, 1'b0, cap_b);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (cap_a !== 8'h00) $display("FAIL under_miso_first: got %h want 00", cap_a); else n_pass++;
        n_total++; if (cap_b !== 8'h00) $display("FAIL under_miso_second: got %h want 00", cap_b); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'hF0) $display("FAIL over_rx_data: got %h want f0", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.OVERRUN !== 1'b1) $display("FAIL over_flag: got %b want 1", bus.OVERRUN); else n_pass++;
        read_pulse();
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL over_read_valid: got %b want 0", bus.RX_VALID); else n_pass++;
        n_total++; if (bus.OVERRUN !== 1'b0) $display("FAIL over_read_overrun: got %b want 0", bus.OVERRUN); else n_pass++;
    endtask

    task automatic test_abort;
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'hFF, 3, 1'b0, cap_a);
        cycles(4);
        bus.SS_N = 1'b1;
        count_abort(12);
        n_total++; if (pulses !== 1) $display("FAIL abort_pulses: got %0d want 1", pulses); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'hF0) $display("FAIL abort_rx_data: got %h want f0", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL abort_rx_valid: got %b want 0", bus.RX_VALID); else n_pass++;
        // Select with no clocks: counter is 0, so no abort.
        bus.SS_N = 1'b0;
        cycles(SETUP);
        bus.SS_N = 1'b1;
        count_abort(12);
        n_total++; if (pulses !== 0) $display("FAIL abort_empty_select: got %0d want 0", pulses); else n_pass++;
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'h5A, 8, 1'b0, cap_a);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (bus.RX_DATA !== 8'h5A) $display("FAIL abort_next_frame: got %h want 5a", bus.RX_DATA); else n_pass++;
        read_pulse();
    endtask

    task automatic test_collision;
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'h12, 8, 1'b0, cap_a);
        xfer(8'h34, 8, 1'b1, cap_b);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (bus.RX_VALID !== 1'b1) $display("FAIL coll_rx_valid: got %b want 1", bus.RX_VALID); else n_pass++;
        n_total++; if (bus.OVERRUN !== 1'b0) $display("FAIL coll_overrun: got %b want 0", bus.OVERRUN); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'h34) $display("FAIL coll_rx_data: got %h want 34", bus.RX_DATA); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        write_word(8'h77);
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'hFF, 4, 1'b0, cap_a);
        rst = 1'b1;
        cycles(1);
        n_total++; if (miso_w !== 1'b1) $display("FAIL clr_miso_released: got %b want 1 (pulled)", miso_w); else n_pass++;
        n_total++; if (bus.BUSY !== 1'b0) $display("FAIL clr_busy: got %b want 0", bus.BUSY); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL clr_rx_valid: got %b want 0", bus.RX_VALID); else n_pass++;
        n_total++; if (bus.RX_DATA !== 8'h00) $display("FAIL clr_rx_data: got %h want 00", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.TX_EMPTY !== 1'b1) $display("FAIL clr_tx_empty: got %b want 1", bus.TX_EMPTY); else n_pass++;
        cycles(1);
        rst = 1'b0;
        // SS_N still low: this whole frame must be ignored.
        xfer(8'h99, 8, 1'b0, cap_a);
        cycles(HALF);
        n_total++; if (bus.BUSY !== 1'b0) $display("FAIL clr_ignore_busy: got %b want 0", bus.BUSY); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b0) $display("FAIL clr_ignore_rx_valid: got %b want 0", bus.RX_VALID); else n_pass++;
        bus.SS_N = 1'b1;
        cycles(SETUP);
        bus.SS_N = 1'b0;
        cycles(SETUP);
        xfer(8'hC3, 8, 1'b0, cap_b);
        cycles(HALF);
        bus.SS_N = 1'b1;
        cycles(HALF);
        n_total++; if (bus.RX_DATA !== 8'hC3) $display("FAIL clr_next_rx_data: got %h want c3", bus.RX_DATA); else n_pass++;
        n_total++; if (bus.RX_VALID !== 1'b1) $display("FAIL clr_next_rx_valid: got %b want 1", bus.RX_VALID); else n_pass++;
        n_total++; if (cap_b !== 8'h00) $display("FAIL clr_next_miso: got %h want 00", cap_b); else n_pass++;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.SCLK    = 1'b0;
        bus.SS_N    = 1'b1;
        bus.MOSI    = 1'b0;
        bus.TX_DATA = 8'h00;
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun_overrun();
        test_abort();
        test_collision();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI responder (slave) end of the team's serial link: receives frames clocked by an external initiator on SCLK/SS_N/MOSI and returns data on MISO. It runs entirely in the local CLK domain, oversampling and synchronising the SPI pins. It sits between the pins and a parallel host interface made of a one-entry TX buffer and a one-entry RX holding register. Mode 0 only (CPOL=0, CPHA=0); frames are LSB first, matching the existing sender/receiver shift order.

## Interface
- DATA_WIDTH, 8: frame length in bits.
- SYNC_STAGES, 2: synchroniser depth on SCLK, SS_N and MOSI (≥2).
- CLK  in  1  local clock; one clock domain for the whole block.
- CLR  in  1  reset, asynchronous, active-high.
- SCLK  in  1  SPI clock from the initiator, asynchronous to CLK.
- SS_N  in  1  slave select, active low, asynchronous.
- MOSI  in  1  serial data from the initiator.
- MISO  out  1  serial data to the initiator; high-Z whenever not selected.
- TX_DATA  in  DATA_WIDTH  word for the next outgoing frame.
- WRITE  in  1  single-cycle strobe that stores TX_DATA in the TX buffer.
- TX_EMPTY  out  1  TX buffer free.
- RX_DATA  out  DATA_WIDTH  last complete received frame (registered, always driven).
- RX_VALID  out  1  RX_DATA holds an unread frame.
- READ  in  1  single-cycle strobe that acknowledges RX_DATA.
- OVERRUN  out  1  sticky flag: a frame overwrote unread data.
- ABORT  out  1  one-cycle pulse: SS_N deasserted mid-frame.
- BUSY  out  1  selected, so a frame is in progress.

## Operation
- Reset values: MISO=Z, TX_EMPTY=1, RX_VALID=0, RX_DATA=0, OVERRUN=0, ABORT=0, BUSY=0. The FSM is in IDLE and the bit counter is 0.
- FSM states:
  - IDLE: MISO=Z. A synchronised SS_N fall moves to LOAD.
  - LOAD: one cycle. The TX shift register loads the TX buffer, or all zeros if TX_EMPTY=1 (underrun sends 0x00). This consumes the buffer, so TX_EMPTY goes to 1. Next state is SHIFT, and MISO drives shreg[0].
  - SHIFT:
    - On each SCLK rising edge, MOSI is shifted into the RX shift register MSB (right shift) and the bit counter increments.
    - On each SCLK falling edge, the TX register shifts right.
    - When the counter reaches DATA_WIDTH: the frame completes, the counter returns to 0, and the FSM returns to LOAD. The reload takes effect on the next falling edge only if SS_N is still low, which gives back-to-back frames.
  - A synchronised SS_N rise in any state returns the FSM to IDLE.
- Frame completion:
  - RX_DATA is loaded from the RX shift register and RX_VALID is set to 1.
  - If RX_VALID was already 1 and READ is not asserted in the same cycle, OVERRUN is set to 1 and the new data overwrites the old.
- READ clears RX_VALID and OVERRUN on the next cycle. If READ coincides with a frame completion, the new frame wins: RX_VALID stays 1 and OVERRUN is not set.
- WRITE behaviour:
  - WRITE with TX_EMPTY=1 stores TX_DATA; TX_EMPTY becomes 0.
  - WRITE with TX_EMPTY=0 is ignored and the buffer is unchanged.
  - WRITE in the same cycle as a LOAD: the LOAD takes the old content and the new word is stored, so TX_EMPTY stays 0.
- SS_N rising while the counter ≠ 0:
  - ABORT pulses for one cycle.
  - The partial RX bits are discarded; RX_DATA and RX_VALID are unchanged.
  - The consumed TX word is not restored.
- SS_N rising when the counter is 0: no ABORT.
- BUSY = (state ≠ IDLE).
- Bit counter width: $clog2(DATA_WIDTH)+1. It never exceeds DATA_WIDTH.

## Timing
- Pin-to-internal latency: SYNC_STAGES cycles, plus 1 cycle for the edge detector.
- SCLK constraints: high and low times must each be ≥ SYNC_STAGES+2 CLK cycles. SCLK ≤ CLK/8 with default parameters.
- SS_N fall to first SCLK rise must be ≥ SYNC_STAGES+3 CLK cycles. This guarantees MISO bit 0 is valid before the first sample.
- MISO changes SYNC_STAGES+2 cycles after an SCLK pin falling edge. Initiators must sample on the rising edge.
- RX_VALID rises SYNC_STAGES+2 cycles after the final SCLK rising edge at the pin.
- TX_EMPTY rises the cycle after LOAD.
- ABORT fires SYNC_STAGES+1 cycles after the SS_N pin rises.
- Asserting CLR mid-frame immediately forces all reset values, including MISO=Z. After CLR deasserts, the block waits for a fresh SS_N fall; an SS_N already low at release is ignored until it goes high.

## Structure
- Package spi_pkg: FSM state enum (IDLE, LOAD, SHIFT), the DATA_WIDTH default and the SYNC_STAGES default. This package is shared with the existing sender/receiver.
- Sub-module spi_sync_edge: SYNC_STAGES flop synchroniser plus rise/fall detect. Instantiated for SCLK and SS_N; MOSI uses the synchroniser only.
- Top level: FSM, bit counter, TX buffer, TX/RX shift registers, RX holding register, flags.

## Test plan
- Basic frame: WRITE 0x3C, then the initiator sends 0xA5 LSB first → RX_DATA=0xA5, RX_VALID=1; the initiator captures 0x3C; TX_EMPTY=1 after LOAD.
- Back-to-back frames: WRITE 0x11, then WRITE 0x22 during frame 1, with SS_N held low for two frames → MISO sends 0x11 then 0x22.
- Underrun and overrun: no WRITE, then two frames 0x0F and 0xF0 with no READ → MISO sends 0x00 twice; RX_DATA=0xF0; OVERRUN=1. A READ then clears RX_VALID and OVERRUN.
- Abort: SS_N rises after 3 SCLK edges of a 0xFF frame → ABORT pulses once; RX_VALID and RX_DATA are unchanged; the next full frame 0x5A is received correctly.
- READ/complete collision: READ is asserted in the exact cycle frame 2 completes → RX_VALID stays 1, OVERRUN=0, RX_DATA=frame 2.
- Reset mid-frame: CLR is pulsed after 4 bits → all outputs take their reset values and MISO=Z. The frame is ignored until SS_N toggles high, then the next frame 0xC3 is received.
